// File: rtl/node_route_sequencer.sv
// Route sequencer: counts debounced node crossings (all sensors dark) and
// presents the programmed turn for the next node, repeating for NUM_LAPS laps.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start, sensors ignored, route table writable
// S_ARMED   | between nodes, qualifying an all-dark sensor pattern
// S_ON_NODE | node counted, qualifying the line pattern clearing again
// S_DONE    | final lap complete, turn held at 11 until start or reset
module node_route_sequencer #(
  parameter int SENSOR_W  = 3,
  parameter int MAX_NODES = 32,
  parameter int NUM_LAPS  = 2,
  parameter int DEBOUNCE  = 4,
  parameter int IDX_W     = $clog2(MAX_NODES),
  parameter int LAP_W     = $clog2(NUM_LAPS + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SENSOR_W-1:0] line_sensor,
  input  logic                cfg_we,
  input  logic [IDX_W-1:0]    cfg_addr,
  input  logic [1:0]          cfg_dir,
  input  logic [IDX_W:0]      cfg_len,
  input  logic                start,
  output logic [1:0]          turn_direction,
  output logic [IDX_W-1:0]    node_idx,
  output logic [LAP_W-1:0]    lap_count,
  output logic                node_pulse,
  output logic                lap_done,
  output logic                busy,
  output logic                done
);

  localparam int LEN_W = IDX_W + 1;
  localparam int DB_W  = $clog2(DEBOUNCE + 1);
  localparam logic [DB_W-1:0]  DB_RELOAD = DB_W'(DEBOUNCE - 1);
  localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_NODES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_ON_NODE = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [IDX_W-1:0]  node_idx_q, node_idx_d;
  logic [LAP_W-1:0]  lap_q, lap_d;
  logic [1:0]        turn_q, turn_d;
  logic              node_pulse_q, node_pulse_d;
  logic              lap_done_q, lap_done_d;
  logic [1:0]        table_q [MAX_NODES];
  logic [1:0]        table_d [MAX_NODES];

  logic              all_dark;
  logic              busy_w;
  logic              wr_en;
  logic              start_ok;
  logic [IDX_W-1:0]  idx_inc;
  logic [LAP_W-1:0]  lap_inc;
  logic              last_in_lap;

  assign all_dark    = &line_sensor;
  assign busy_w      = (state_q == S_ARMED) || (state_q == S_ON_NODE);
  assign wr_en       = cfg_we && !busy_w;
  assign start_ok    = start && !busy_w && (cfg_len != '0);
  assign idx_inc     = node_idx_q + IDX_W'(1);
  assign lap_inc     = lap_q + LAP_W'(1);
  assign last_in_lap = !(({1'b0, node_idx_q} + LEN_W'(1)) < len_q);

  always_comb begin
    for (int i = 0; i < MAX_NODES; i++) begin
      table_d[i] = table_q[i];
      if (wr_en && (cfg_addr == IDX_W'(i))) begin
        table_d[i] = cfg_dir;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    db_cnt_d     = db_cnt_q;
    len_d        = len_q;
    node_idx_d   = node_idx_q;
    lap_d        = lap_q;
    turn_d       = turn_q;
    node_pulse_d = 1'b0;
    lap_done_d   = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          state_d    = S_ARMED;
          db_cnt_d   = DB_RELOAD;
          len_d      = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
          node_idx_d = '0;
          lap_d      = '0;
          // table_d so a same-cycle write to entry 0 is already visible
          turn_d     = table_d[0];
        end
      end

      S_ARMED: begin
        if (!all_dark) begin
          db_cnt_d = DB_RELOAD;
        end else if (db_cnt_q != '0) begin
          db_cnt_d = db_cnt_q - DB_W'(1);
        end else begin
          db_cnt_d     = DB_RELOAD;
          node_pulse_d = 1'b1;
          state_d      = S_ON_NODE;
          if (!last_in_lap) begin
            node_idx_d = idx_inc;
            turn_d     = table_q[idx_inc];
          end else begin
            node_idx_d = '0;
            lap_d      = lap_inc;
            lap_done_d = 1'b1;
            turn_d     = table_q[0];
            if (lap_inc == LAP_W'(NUM_LAPS)) begin
              state_d = S_DONE;
              turn_d  = 2'b11;
            end
          end
        end
      end

      S_ON_NODE: begin
        if (all_dark) begin
          db_cnt_d = DB_RELOAD;
        end else if (db_cnt_q != '0) begin
          db_cnt_d = db_cnt_q - DB_W'(1);
        end else begin
          db_cnt_d = DB_RELOAD;
          state_d  = S_ARMED;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      db_cnt_q     <= DB_RELOAD;
      len_q        <= '0;
      node_idx_q   <= '0;
      lap_q        <= '0;
      turn_q       <= 2'b00;
      node_pulse_q <= 1'b0;
      lap_done_q   <= 1'b0;
      for (int i = 0; i < MAX_NODES; i++) begin
        table_q[i] <= 2'b00;
      end
    end else begin
      state_q      <= state_d;
      db_cnt_q     <= db_cnt_d;
      len_q        <= len_d;
      node_idx_q   <= node_idx_d;
      lap_q        <= lap_d;
      turn_q       <= turn_d;
      node_pulse_q <= node_pulse_d;
      lap_done_q   <= lap_done_d;
      for (int i = 0; i < MAX_NODES; i++) begin
        table_q[i] <= table_d[i];
      end
    end
  end

  assign turn_direction = turn_q;
  assign node_idx       = node_idx_q;
  assign lap_count      = lap_q;
  assign node_pulse     = node_pulse_q;
  assign lap_done       = lap_done_q;
  assign busy           = busy_w;
  assign done           = (state_q == S_DONE);

endmodule
